// File: rtl/oled_pkg.sv
// Shared screen geometry, RGB565 colours and helpers for the OLED pixel-source renderers.
package oled_pkg;

    localparam int SCR_W   = 96;
    localparam int SCR_H   = 64;
    localparam int NPIX    = 6144;
    // Only referenced when the floor option (OLED_FLOOR_EN) is compiled in.
    localparam int FLOOR_Y = 60;

    typedef logic [15:0] rgb565_t;

    localparam rgb565_t COL_BLACK = 16'h0000;
    localparam rgb565_t COL_BLUE  = 16'h001F;
    localparam rgb565_t COL_RED   = 16'hF800;
    localparam rgb565_t COL_GREEN = 16'h07E0;
    localparam rgb565_t COL_GREY  = 16'h4208;
    localparam rgb565_t COL_WHITE = 16'hFFFF;
    localparam rgb565_t COL_BROWN = 16'h8200;

    function automatic logic [5:0] clamp_hp(input logic [5:0] hp, input logic [5:0] hp_max);
        return (hp > hp_max) ? hp_max : hp;
    endfunction

endpackage

// File: rtl/oled_index_to_xy.sv
// Registered split of a row-major pixel index into (x, y) on the 96x64 panel.
// Out-of-range indices raise oor_o and report (0, 0).
module oled_index_to_xy
    import oled_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] index_i,
    output logic [6:0]  x_o,
    output logic [5:0]  y_o,
    output logic        oor_o
);

    logic [6:0] x_d, x_q;
    logic [5:0] y_d, y_q;
    logic       oor_d, oor_q;

    // index/96 = (index/32)/3; n*171>>9 equals n/3 exactly for n < 512.
    always_comb begin
        oor_d = (index_i >= 13'(NPIX));
        y_d   = 6'((17'(index_i[12:5]) * 17'd171) >> 9);
        x_d   = 7'(index_i - 13'(y_d) * 13'd96);
        if (oor_d) begin
            x_d = '0;
            y_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q   <= '0;
            y_q   <= '0;
            oor_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            oor_q <= oor_d;
        end
    end

    assign x_o   = x_q;
    assign y_o   = y_q;
    assign oor_o = oor_q;

endmodule

// File: rtl/oled_fighter_renderer.sv
// Fight-scene pixel source: two fighter boxes, two health bars, hit flash; 2-clk index-to-colour latency.
// Optional OLED_FLOOR_EN paints uncovered rows y >= FLOOR_Y brown.
module oled_fighter_renderer
    import oled_pkg::*;
#(
    parameter int FW           = 12,
    parameter int FH           = 20,
    parameter int HP_MAX       = 40,
    parameter int HP_LOW       = 10,
    parameter int FLASH_FRAMES = 8
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_begin,
    input  logic [12:0] pixel_index,
    input  logic [6:0]  p1_x,
    input  logic [5:0]  p1_y,
    input  logic [6:0]  p2_x,
    input  logic [5:0]  p2_y,
    input  logic [5:0]  p1_hp,
    input  logic [5:0]  p2_hp,
    input  logic        hit1,
    input  logic        hit2,
    output logic [15:0] pixel_data
);

    logic [6:0] x_q;
    logic [5:0] y_q;
    logic       oor_q;

    oled_index_to_xy u_xy (
        .clk     (clk),
        .reset   (reset),
        .index_i (pixel_index),
        .x_o     (x_q),
        .y_o     (y_q),
        .oor_o   (oor_q)
    );

    logic [6:0] p1_x_q, p2_x_q;
    logic [5:0] p1_y_q, p2_y_q, p1_hp_q, p2_hp_q;
    logic [3:0] flash1_d, flash1_q, flash2_d, flash2_q;
    rgb565_t    pixel_d, pixel_q;

    // Scene state is only sampled at frame start so a frame never tears.
    always_ff @(posedge clk) begin
        if (reset) begin
            p1_x_q  <= '0;
            p1_y_q  <= '0;
            p2_x_q  <= '0;
            p2_y_q  <= '0;
            p1_hp_q <= '0;
            p2_hp_q <= '0;
        end else if (frame_begin) begin
            p1_x_q  <= p1_x;
            p1_y_q  <= p1_y;
            p2_x_q  <= p2_x;
            p2_y_q  <= p2_y;
            p1_hp_q <= p1_hp;
            p2_hp_q <= p2_hp;
        end
    end

    always_comb begin
        flash1_d = flash1_q;
        flash2_d = flash2_q;
        if (hit1)
            flash1_d = 4'(FLASH_FRAMES);
        else if (frame_begin && flash1_q != 4'd0)
            flash1_d = flash1_q - 4'd1;
        if (hit2)
            flash2_d = 4'(FLASH_FRAMES);
        else if (frame_begin && flash2_q != 4'd0)
            flash2_d = flash2_q - 4'd1;
    end

    logic [7:0] x8, y8, p1x8, p1y8, p2x8, p2y8;
    logic [5:0] hp1c, hp2c;
    logic       in_p1, in_p2, bar_row, p1_span, p2_span, p1_fill, p2_fill;

    // Box tests run in 8 bits so px+FW-1 cannot wrap back onto the left edge.
    always_comb begin
        x8    = {1'b0, x_q};
        y8    = {2'b00, y_q};
        p1x8  = {1'b0, p1_x_q};
        p1y8  = {2'b00, p1_y_q};
        p2x8  = {1'b0, p2_x_q};
        p2y8  = {2'b00, p2_y_q};
        in_p1 = (x8 >= p1x8) && (x8 <= p1x8 + 8'(FW - 1)) &&
                (y8 >= p1y8) && (y8 <= p1y8 + 8'(FH - 1));
        in_p2 = (x8 >= p2x8) && (x8 <= p2x8 + 8'(FW - 1)) &&
                (y8 >= p2y8) && (y8 <= p2y8 + 8'(FH - 1));

        hp1c    = clamp_hp(p1_hp_q, 6'(HP_MAX));
        hp2c    = clamp_hp(p2_hp_q, 6'(HP_MAX));
        bar_row = (y_q >= 6'd1) && (y_q <= 6'd3);
        p1_span = (x_q >= 7'd1) && (x_q <= 7'(HP_MAX));
        p2_span = (x_q >= 7'(SCR_W - 1 - HP_MAX)) && (x_q <= 7'(SCR_W - 2));
        p1_fill = (x_q <= {1'b0, hp1c});
        p2_fill = (x_q >= 7'(SCR_W - 1) - {1'b0, hp2c});
    end

    always_comb begin
        pixel_d = COL_BLACK;
        if (oor_q)
            pixel_d = COL_BLACK;
        else if (bar_row && p1_span)
            pixel_d = !p1_fill ? COL_GREY : (hp1c >= 6'(HP_LOW)) ? COL_GREEN : COL_RED;
        else if (bar_row && p2_span)
            pixel_d = !p2_fill ? COL_GREY : (hp2c >= 6'(HP_LOW)) ? COL_GREEN : COL_RED;
        else if (in_p1)
            pixel_d = (flash1_q != 4'd0 && flash1_q[0]) ? COL_WHITE : COL_BLUE;
        else if (in_p2)
            pixel_d = (flash2_q != 4'd0 && flash2_q[0]) ? COL_WHITE : COL_RED;
`ifdef OLED_FLOOR_EN
        else if (y_q >= 6'(FLOOR_Y))
            pixel_d = COL_BROWN;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flash1_q <= '0;
            flash2_q <= '0;
            pixel_q  <= COL_BLACK;
        end else begin
            flash1_q <= flash1_d;
            flash2_q <= flash2_d;
            pixel_q  <= pixel_d;
        end
    end

    assign pixel_data = pixel_q;

endmodule

// File: tb/tb_oled_fighter_renderer.sv
// Directed bench for oled_fighter_renderer with hand-computed expected colours.
module tb_oled_fighter_renderer;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_begin;
    logic [12:0] pixel_index;
    logic [6:0]  p1_x, p2_x;
    logic [5:0]  p1_y, p2_y, p1_hp, p2_hp;
    logic        hit1, hit2;
    logic [15:0] pixel_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    oled_fighter_renderer dut (
        .clk         (clk),
        .reset       (reset),
        .frame_begin (frame_begin),
        .pixel_index (pixel_index),
        .p1_x        (p1_x),
        .p1_y        (p1_y),
        .p2_x        (p2_x),
        .p2_y        (p2_y),
        .p1_hp       (p1_hp),
        .p2_hp       (p2_hp),
        .hit1        (hit1),
        .hit2        (hit2),
        .pixel_data  (pixel_data)
    );

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic probe(input string tag, input logic [12:0] idx, input logic [15:0] exp);
        pixel_index = idx;
        repeat (2) @(posedge clk);
        #1;
        check_eq(tag, pixel_data, exp);
    endtask

    task automatic frame();
        frame_begin = 1'b1;
        @(posedge clk);
        #1;
        frame_begin = 1'b0;
    endtask

    task automatic place(input logic [6:0] x1, input logic [5:0] y1,
                         input logic [6:0] x2, input logic [5:0] y2,
                         input logic [5:0] h1, input logic [5:0] h2);
        p1_x = x1; p1_y = y1; p2_x = x2; p2_y = y2; p1_hp = h1; p2_hp = h2;
        frame();
    endtask

    initial begin
        reset = 1'b1; frame_begin = 1'b0; pixel_index = '0;
        p1_x = '0; p1_y = '0; p2_x = '0; p2_y = '0; p1_hp = '0; p2_hp = '0;
        hit1 = 1'b0; hit2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_hold_idx0", pixel_data, 16'h0000);
        reset = 1'b0;

        // Fighters parked off-screen, hp 0: pixel 0 is plain background.
        place(7'd100, 6'd0, 7'd100, 6'd0, 6'd0, 6'd0);
        probe("bg_idx0", 13'd0, 16'h0000);
        probe("hp0_p1_grey", 13'd97, 16'h4208);
        probe("hp0_p2_grey", 13'd156, 16'h4208);

        // New position without frame_begin must not show yet.
        p1_x = 7'd10; p1_y = 6'd30;
        probe("shadow_hold", 13'd2890, 16'h0000);
        frame();
        probe("p1_topleft", 13'd2890, 16'h001F);
        probe("p1_left_out", 13'd2889, 16'h0000);
        probe("p1_botright", 13'd4725, 16'h001F);
        probe("p1_below", 13'd4821, 16'h0000);
        probe("p1_right_out", 13'd4726, 16'h0000);

        place(7'd10, 6'd30, 7'd15, 6'd30, 6'd0, 6'd0);
        probe("overlap_p1_prio", 13'd2896, 16'h001F);
        probe("p2_only", 13'd2905, 16'hF800);

        place(7'd100, 6'd0, 7'd90, 6'd30, 6'd0, 6'd0);
        probe("p2_clip_x95", 13'd2975, 16'hF800);
        probe("p2_no_wrap_x0", 13'd2880, 16'h0000);
        probe("p2_clip_x90", 13'd2970, 16'hF800);
        probe("p2_clip_x89", 13'd2969, 16'h0000);

        place(7'd100, 6'd40, 7'd100, 6'd40, 6'd5, 6'd3);
        probe("bar1_red_x3", 13'd195, 16'hF800);
        probe("bar1_grey_x20", 13'd212, 16'h4208);
        probe("bar1_row1_x1", 13'd97, 16'hF800);
        probe("bar1_row3_x5", 13'd293, 16'hF800);
        probe("bar1_row3_x6", 13'd294, 16'h4208);
        probe("bar1_x40", 13'd232, 16'h4208);
        probe("bar_row0", 13'd3, 16'h0000);
        probe("bar_row4", 13'd387, 16'h0000);
        probe("bar2_x92", 13'd284, 16'hF800);
        probe("bar2_x91", 13'd283, 16'h4208);
        probe("bar2_x95", 13'd287, 16'h0000);
        probe("bar2_x55", 13'd247, 16'h4208);
        probe("bar2_x54", 13'd246, 16'h0000);

        place(7'd100, 6'd40, 7'd100, 6'd40, 6'd63, 6'd40);
        probe("bar1_clamp_x41", 13'd233, 16'h0000);
        probe("bar1_clamp_x40", 13'd232, 16'h07E0);
        probe("bar2_full_x55", 13'd247, 16'h07E0);

        place(7'd100, 6'd40, 7'd100, 6'd40, 6'd10, 6'd9);
        probe("bar1_hp10_green", 13'd202, 16'h07E0);
        probe("bar1_hp10_x11", 13'd203, 16'h4208);
        probe("bar2_hp9_red", 13'd278, 16'hF800);
        probe("bar2_hp9_x85", 13'd277, 16'h4208);

        place(7'd0, 6'd0, 7'd100, 6'd40, 6'd5, 6'd0);
        probe("bar_over_p1", 13'd97, 16'hF800);
        probe("p1_outside_span", 13'd96, 16'h001F);

        // Flash: hit together with frame_begin loads 8, then counts down per frame.
        place(7'd10, 6'd30, 7'd30, 6'd30, 6'd0, 6'd0);
        hit1 = 1'b1; frame_begin = 1'b1;
        @(posedge clk);
        #1;
        hit1 = 1'b0; frame_begin = 1'b0;
        probe("flash_load8", 13'd2890, 16'h001F);
        for (int f = 1; f <= 8; f++) begin
            frame();
            probe($sformatf("flash_cnt%0d", 8 - f), 13'd2890,
                  ((8 - f) % 2 == 1) ? 16'hFFFF : 16'h001F);
        end
        frame();
        probe("flash_stays0", 13'd2890, 16'h001F);

        hit1 = 1'b1;
        @(posedge clk);
        #1;
        hit1 = 1'b0;
        frame();
        probe("flash_reload7", 13'd2890, 16'hFFFF);
        hit1 = 1'b1;
        @(posedge clk);
        #1;
        hit1 = 1'b0;
        probe("flash_reload8", 13'd2890, 16'h001F);
        repeat (8) frame();
        probe("flash_cleared", 13'd2890, 16'h001F);

        hit2 = 1'b1;
        @(posedge clk);
        #1;
        hit2 = 1'b0;
        frame();
        probe("p2_flash7", 13'd2910, 16'hFFFF);
        frame();
        probe("p2_flash6", 13'd2910, 16'hF800);

        // A wrapped decode of an out-of-range index would land on P1 at (0,0).
        place(7'd0, 6'd0, 7'd100, 6'd40, 6'd0, 6'd0);
        probe("p1_at_origin", 13'd0, 16'h001F);
        probe("oor_6144", 13'd6144, 16'h0000);
        probe("oor_8191", 13'd8191, 16'h0000);
        probe("last_pixel", 13'd6143, 16'h0000);

        place(7'd10, 6'd30, 7'd100, 6'd0, 6'd0, 6'd0);
        probe("pre_midreset", 13'd2890, 16'h001F);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midreset_zero", pixel_data, 16'h0000);
        reset = 1'b0;
        probe("post_reset_shadow0", 13'd2890, 16'h0000);
        place(7'd10, 6'd30, 7'd100, 6'd0, 6'd0, 6'd0);
        probe("post_reset_resume", 13'd2890, 16'h001F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
